// File: rtl/ili9341_frame_streamer_pkg.sv
// ili9341_frame_streamer_pkg: shared FSM states and display constants
package ili9341_frame_streamer_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CUR_REQ, S_CUR_ACK, S_CUR_WAIT, S_FETCH, S_LOOKUP,
    S_PIX_REQ, S_PIX_ACK, S_PIX_WAIT, S_ADVANCE, S_DONE
  } state_t;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam int DISP_W = 240;
  localparam int DISP_H = 320;
endpackage

// File: rtl/ili9341_frame_streamer_palette.sv
// ili9341_frame_streamer_palette: RGB565 palette with sync write and async read
module ili9341_frame_streamer_palette #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [15:0]      rdata
);
  logic [15:0] mem_q [2**IDX_W];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/ili9341_frame_streamer.sv
// ili9341_frame_streamer: walks an indexed framebuffer, pixel-doubles it and streams RGB565 to the LCD driver
module ili9341_frame_streamer
  import ili9341_frame_streamer_pkg::*;
#(
  parameter int SRC_W  = 120,
  parameter int SRC_H  = 160,
  parameter int SCALE  = 2,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 15
) (
  input  logic              clk_16MHz,
  input  logic              reset,
  input  logic              frame_start,
  output logic              active,
  output logic              frame_done,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [IDX_W-1:0]  fb_data,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [15:0]       pal_wdata,
  input  logic              lcd_busy,
  output logic              reset_cursor,
  output logic [15:0]       pix_data,
  output logic              pix_clk
);
  localparam int XR_W = $clog2(SCALE + 1);
  localparam int XS_W = $clog2(SRC_W + 1);
  localparam int YS_W = $clog2(SRC_H + 1);
  localparam logic [XR_W-1:0] REP_MAX = XR_W'(SCALE - 1);
  localparam logic [XS_W-1:0] XS_MAX = XS_W'(SRC_W - 1);
  localparam logic [YS_W-1:0] YS_MAX = YS_W'(SRC_H - 1);
  state_t state_q, state_d;
  logic active_q, active_d, frame_done_q, frame_done_d;
  logic reset_cursor_q, reset_cursor_d, pix_clk_q, pix_clk_d;
  logic [15:0] pix_data_q, pix_data_d, pal_rdata;
  logic [XR_W-1:0] x_rep_q, x_rep_d, y_rep_q, y_rep_d;
  logic [XS_W-1:0] x_src_q, x_src_d;
  logic [YS_W-1:0] y_src_q, y_src_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic xr_last, line_wrap, pass_wrap;
  ili9341_frame_streamer_palette #(.IDX_W(IDX_W)) u_pal (
    .clk(clk_16MHz), .we(pal_we), .waddr(pal_addr), .wdata(pal_wdata),
    .raddr(fb_data), .rdata(pal_rdata)
  );
  assign active       = active_q;
  assign frame_done   = frame_done_q;
  assign reset_cursor = reset_cursor_q;
  assign pix_clk      = pix_clk_q;
  assign pix_data     = pix_data_q;
  assign fb_addr      = row_base_q + ADDR_W'(x_src_q);
  always_ff @(posedge clk_16MHz) begin
    if (reset) begin
      state_q        <= S_IDLE;
      active_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      reset_cursor_q <= 1'b0;
      pix_clk_q      <= 1'b0;
      pix_data_q     <= RGB565_BLACK;
      x_rep_q        <= '0;
      y_rep_q        <= '0;
      x_src_q        <= '0;
      y_src_q        <= '0;
      row_base_q     <= '0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      frame_done_q   <= frame_done_d;
      reset_cursor_q <= reset_cursor_d;
      pix_clk_q      <= pix_clk_d;
      pix_data_q     <= pix_data_d;
      x_rep_q        <= x_rep_d;
      y_rep_q        <= y_rep_d;
      x_src_q        <= x_src_d;
      y_src_q        <= y_src_d;
      row_base_q     <= row_base_d;
    end
  end
  always_comb begin
    xr_last        = x_rep_q == REP_MAX;
    line_wrap      = xr_last && x_src_q == XS_MAX;
    pass_wrap      = line_wrap && y_rep_q == REP_MAX;
    state_d        = state_q;
    active_d       = active_q;
    frame_done_d   = 1'b0;
    reset_cursor_d = reset_cursor_q;
    pix_clk_d      = pix_clk_q;
    pix_data_d     = pix_data_q;
    x_rep_d        = x_rep_q;
    y_rep_d        = y_rep_q;
    x_src_d        = x_src_q;
    y_src_d        = y_src_q;
    row_base_d     = row_base_q;
    case (state_q)
      S_IDLE: begin
        state_d  = frame_start ? S_CUR_REQ : S_IDLE;
        active_d = frame_start;
      end
      S_CUR_REQ: begin
        state_d        = lcd_busy ? S_CUR_REQ : S_CUR_ACK;
        reset_cursor_d = !lcd_busy;
      end
      S_CUR_ACK: begin
        state_d        = lcd_busy ? S_CUR_WAIT : S_CUR_ACK;
        reset_cursor_d = !lcd_busy;
      end
      S_CUR_WAIT: state_d = lcd_busy ? S_CUR_WAIT : S_FETCH;
      S_FETCH:    state_d = S_LOOKUP;
      S_LOOKUP: begin
        pix_data_d = pal_rdata;
        state_d    = S_PIX_REQ;
      end
      S_PIX_REQ: begin
        state_d   = lcd_busy ? S_PIX_REQ : S_PIX_ACK;
        pix_clk_d = !lcd_busy;
      end
      S_PIX_ACK: begin
        state_d   = lcd_busy ? S_PIX_WAIT : S_PIX_ACK;
        pix_clk_d = !lcd_busy;
      end
      S_PIX_WAIT: state_d = lcd_busy ? S_PIX_WAIT : S_ADVANCE;
      S_ADVANCE: begin
        x_rep_d    = xr_last ? '0 : x_rep_q + 1'b1;
        x_src_d    = !xr_last ? x_src_q : line_wrap ? '0 : x_src_q + 1'b1;
        y_rep_d    = !line_wrap ? y_rep_q : pass_wrap ? '0 : y_rep_q + 1'b1;
        y_src_d    = !pass_wrap ? y_src_q : y_src_q == YS_MAX ? '0 : y_src_q + 1'b1;
        row_base_d = !pass_wrap ? row_base_q : y_src_q == YS_MAX ? '0 : row_base_q + ADDR_W'(SRC_W);
        state_d    = pass_wrap && y_src_q == YS_MAX ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        active_d     = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ili9341_frame_streamer.sv
// tb_ili9341_frame_streamer: randomized-busy driver model with frame reference model for two DUT sizes
module tb_ili9341_frame_streamer;
  import ili9341_frame_streamer_pkg::*;
  localparam int AW = 2, AH = 2, AS = 2;
  localparam int BW = 10, BH = 8, BS = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic fs [2], active [2], fdone [2], pal_we [2], lcd_busy [2], rcur [2], pclk [2];
  logic [14:0] fb_addr [2];
  logic [3:0] fb_data [2], pal_addr [2];
  logic [15:0] pal_wdata [2], pix_data [2];
  logic drv_busy [2], man_en [2], man_busy [2], kind [2], pc_prev [2], rc_prev [2];
  logic [7:0] hi [2];
  int hold [2];
  logic [3:0] fbm [2][0:127];
  logic [15:0] pal_ref [2][0:15];
  logic [15:0] cap [2][0:16383];
  int cap_n [2] = '{0, 0};
  int pix_rises [2] = '{0, 0};
  int cur_rises [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int max_addr [2] = '{0, 0};
  int checks = 0, errors = 0;
  assign lcd_busy[0] = man_en[0] ? man_busy[0] : drv_busy[0];
  assign lcd_busy[1] = man_en[1] ? man_busy[1] : drv_busy[1];
  ili9341_frame_streamer #(.SRC_W(AW), .SRC_H(AH), .SCALE(AS)) dut0 (
    .clk_16MHz(clk), .reset(rst), .frame_start(fs[0]), .active(active[0]), .frame_done(fdone[0]),
    .fb_addr(fb_addr[0]), .fb_data(fb_data[0]), .pal_we(pal_we[0]), .pal_addr(pal_addr[0]),
    .pal_wdata(pal_wdata[0]), .lcd_busy(lcd_busy[0]), .reset_cursor(rcur[0]),
    .pix_data(pix_data[0]), .pix_clk(pclk[0])
  );
  ili9341_frame_streamer #(.SRC_W(BW), .SRC_H(BH), .SCALE(BS)) dut1 (
    .clk_16MHz(clk), .reset(rst), .frame_start(fs[1]), .active(active[1]), .frame_done(fdone[1]),
    .fb_addr(fb_addr[1]), .fb_data(fb_data[1]), .pal_we(pal_we[1]), .pal_addr(pal_addr[1]),
    .pal_wdata(pal_wdata[1]), .lcd_busy(lcd_busy[1]), .reset_cursor(rcur[1]),
    .pix_data(pix_data[1]), .pix_clk(pclk[1])
  );
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      fb_data[i] <= fbm[i][fb_addr[i][6:0]];
      if (rst) begin
        drv_busy[i] <= 1'b0;
        hold[i]     <= 0;
      end else if (drv_busy[i]) begin
        if (hold[i] == 0) begin
          drv_busy[i] <= 1'b0;
          if (kind[i]) begin
            cap[i][cap_n[i]] <= {hi[i], pix_data[i][7:0]};
            cap_n[i]         <= cap_n[i] + 1;
          end
        end else hold[i] <= hold[i] - 1;
      end else if (!man_en[i] && (pclk[i] || rcur[i])) begin
        drv_busy[i] <= 1'b1;
        hold[i]     <= $urandom_range(0, 6);
        kind[i]     <= pclk[i];
        hi[i]       <= pix_data[i][15:8];
      end
      pc_prev[i] <= pclk[i];
      rc_prev[i] <= rcur[i];
      if (pclk[i] && !pc_prev[i]) pix_rises[i] <= pix_rises[i] + 1;
      if (rcur[i] && !rc_prev[i]) cur_rises[i] <= cur_rises[i] + 1;
      if (fdone[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (fs[i]) max_addr[i] <= 0;
      else if (int'(fb_addr[i]) > max_addr[i]) max_addr[i] <= int'(fb_addr[i]);
    end
  end
  function automatic int exp_idx(int i, int k);
    int w = (i == 0) ? AW : BW;
    int s = (i == 0) ? AS : BS;
    int row = k / (w * s);
    int col = k % (w * s);
    return int'(fbm[i][(row / s) * w + col / s]);
  endfunction
  task automatic pulse_start(int i);
    @(negedge clk) fs[i] = 1'b1;
    @(negedge clk) fs[i] = 1'b0;
  endtask
  task automatic wait_done(int i, int base, int budget, string name);
    int n = 0;
    while (done_cnt[i] == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt[i] == base) begin
      errors++;
      $display("FAIL %s timeout: frame_done not seen in %0d cycles (required within budget)", name, budget);
    end
  endtask
  task automatic check_frame(int i, int base, int hit_k, string name);
    int total = (i == 0) ? AW * AH * AS * AS : BW * BH * BS * BS;
    int bad = -1;
    logic [15:0] e, bad_e;
    checks++;
    if (cap_n[i] - base != total) begin
      errors++;
      $display("FAIL %s pixel count: got %0d required %0d", name, cap_n[i] - base, total);
    end
    for (int k = 0; k < total; k++) begin
      e = (hit_k >= 0 && k > hit_k && exp_idx(i, k) == 3) ? 16'hF800 : pal_ref[i][exp_idx(i, k)];
      if (cap[i][base + k] !== e && bad < 0) begin
        bad = k;
        bad_e = e;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s pixel %0d: got %h required %h", name, bad, cap[i][base + bad], bad_e);
    end
  endtask
  task automatic load_pal(int i, int e, logic [15:0] v);
    @(negedge clk);
    pal_we[i] = 1'b1;
    pal_addr[i] = 4'(e);
    pal_wdata[i] = v;
    @(negedge clk);
    pal_we[i] = 1'b0;
    pal_ref[i][e] = v;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({active[i], fdone[i], rcur[i], pclk[i], pix_data[i], fb_addr[i]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h required 0", i,
                 {active[i], fdone[i], rcur[i], pclk[i], pix_data[i], fb_addr[i]});
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 16; e++) load_pal(0, e, 16'(16'h1111 * e));
    for (int e = 0; e < 16; e++) load_pal(1, e, 16'($urandom));
    fbm[0][0] = 4'd1; fbm[0][1] = 4'd2; fbm[0][2] = 4'd3; fbm[0][3] = 4'd4;
    for (int a = 0; a < BW * BH; a++) fbm[1][a] = 4'($urandom_range(0, 15));
  endtask
  task automatic test_small_frame();
    int base = cap_n[0], db = done_cnt[0], pr = pix_rises[0];
    @(negedge clk) fs[0] = 1'b1;
    @(negedge clk) fs[0] = 1'b0;
    checks++;
    if (active[0] !== 1'b1 || rcur[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_latency1: active=%b reset_cursor=%b required 1 0", active[0], rcur[0]);
    end
    @(negedge clk);
    checks++;
    if (rcur[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_latency2: reset_cursor=%b required 1", rcur[0]);
    end
    wait_done(0, db, 2000, "small_done");
    repeat (5) @(negedge clk);
    check_frame(0, base, -1, "small_seq");
    checks++;
    if (done_cnt[0] - db != 1 || pix_rises[0] - pr != 16 || active[0] !== 1'b0) begin
      errors++;
      $display("FAIL small_counts: done=%0d rises=%0d active=%b required 1 16 0",
               done_cnt[0] - db, pix_rises[0] - pr, active[0]);
    end
  endtask
  task automatic test_busy_hold();
    int base = cap_n[0], db = done_cnt[0], pr = pix_rises[0], viol = 0;
    @(negedge clk);
    man_en[0] = 1'b1;
    man_busy[0] = 1'b1;
    pulse_start(0);
    repeat (50) begin
      @(negedge clk);
      if (rcur[0] || pclk[0] || pix_rises[0] != pr) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL busy_hold: %0d cycles with a request while busy, required 0", viol);
    end
    man_busy[0] = 1'b0;
    man_en[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rcur[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_release: reset_cursor=%b required 1", rcur[0]);
    end
    wait_done(0, db, 2000, "busy_done");
    repeat (3) @(negedge clk);
    check_frame(0, base, -1, "busy_seq");
  endtask
  task automatic test_full_frame();
    int base = cap_n[1], db = done_cnt[1], pr = pix_rises[1];
    pulse_start(1);
    wait_done(1, db, 40000, "full_done");
    repeat (5) @(negedge clk);
    check_frame(1, base, -1, "full_seq");
    checks++;
    if (pix_rises[1] - pr != BW * BH * BS * BS || max_addr[1] != BW * BH - 1) begin
      errors++;
      $display("FAIL full_counts: rises=%0d max_addr=%0d required %0d %0d",
               pix_rises[1] - pr, max_addr[1], BW * BH * BS * BS, BW * BH - 1);
    end
    checks++;
    if (done_cnt[1] - db != 1 || active[1] !== 1'b0) begin
      errors++;
      $display("FAIL full_done_once: done=%0d active=%b required 1 0", done_cnt[1] - db, active[1]);
    end
  endtask
  task automatic test_palette_race();
    int base = cap_n[0], db = done_cnt[0], n = 0;
    fork
      begin
        pulse_start(0);
        wait_done(0, db, 2000, "race_done");
      end
      begin
        while (!(dut0.state_q == S_LOOKUP && fb_data[0] == 4'd3) && n < 2000) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (n >= 2000) begin
          errors++;
          $display("FAIL race_trigger: lookup of index 3 not seen, required within 2000 cycles");
        end
        pal_we[0] = 1'b1;
        pal_addr[0] = 4'd3;
        pal_wdata[0] = 16'hF800;
        @(negedge clk);
        pal_we[0] = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check_frame(0, base, 8, "race_seq");
    checks++;
    if (cap[0][base + 8] !== 16'h3333 || cap[0][base + 9] !== 16'hF800) begin
      errors++;
      $display("FAIL race_pair: got %h %h required 3333 f800", cap[0][base + 8], cap[0][base + 9]);
    end
    pal_ref[0][3] = 16'hF800;
  endtask
  task automatic test_reset_mid();
    int pr = pix_rises[1], n = 0, db, cr, base;
    pulse_start(1);
    while (pix_rises[1] - pr < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({active[1], fdone[1], rcur[1], pclk[1], pix_data[1], fb_addr[1]} !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h required 0",
               {active[1], fdone[1], rcur[1], pclk[1], pix_data[1], fb_addr[1]});
    end
    rst = 1'b0;
    db = done_cnt[1];
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt[1] != db || active[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: done=%0d active=%b required %0d 0", done_cnt[1], active[1], db);
    end
    cr = cur_rises[1];
    base = cap_n[1];
    pulse_start(1);
    wait_done(1, db, 40000, "restart_done");
    repeat (3) @(negedge clk);
    check_frame(1, base, -1, "restart_seq");
    checks++;
    if (cur_rises[1] - cr != 1) begin
      errors++;
      $display("FAIL restart_cursor: reset_cursor rises=%0d required 1", cur_rises[1] - cr);
    end
  endtask
  task automatic test_back_to_back();
    int base = cap_n[0], db = done_cnt[0], pr = pix_rises[0], n = 0;
    pulse_start(0);
    while (done_cnt[0] == db && n < 2000) begin
      @(negedge clk);
      n++;
      fs[0] = active[0] && (n % 5 == 0);
    end
    fs[0] = 1'b0;
    repeat (20) @(negedge clk);
    check_frame(0, base, -1, "ignore_seq");
    checks++;
    if (done_cnt[0] - db != 1 || pix_rises[0] - pr != 16 || active[0] !== 1'b0) begin
      errors++;
      $display("FAIL ignore_counts: done=%0d rises=%0d active=%b required 1 16 0",
               done_cnt[0] - db, pix_rises[0] - pr, active[0]);
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      fs[i] = 1'b0; pal_we[i] = 1'b0; pal_addr[i] = '0; pal_wdata[i] = '0;
      man_en[i] = 1'b0; man_busy[i] = 1'b0;
    end
    test_reset();
    test_small_frame();
    test_busy_hold();
    test_full_frame();
    test_palette_race();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, required to end on its own");
    $fatal(1);
  end
endmodule
